instr_executor: RTL and testbench

Sequential reader/executor for the instruction register. Walks a programmed range of register slots by driving `read_index`, samples the combinational `instruction` readback, computes the arithmetic result for each entry and presents it on a valid/ready result port. Sits on the read side of the instruction register interface, opposite the load path driven by the test generator.

---
 rtl/instr_executor.sv | 161 ++++++++++++++++
 tb/tb_instr_executor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_executor.sv
// rtl/instr_executor.sv - sequential reader/executor for the instruction register
module instr_executor #(
  parameter  int DEPTH = 32,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_en,
  input  logic                 start,
  input  logic [IW-1:0]        start_index,
  input  logic [IW:0]          count,
  output logic [IW-1:0]        read_index,
  input  logic [3:0]           opcode,
  input  logic [31:0]          operand_a,
  input  logic [31:0]          operand_b,
  output logic [63:0]          result,
  output logic [IW-1:0]        result_index,
  output logic                 result_err,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [3:0] {
    OP_ZERO  = 4'd0,
    OP_PASSA = 4'd1,
    OP_PASSB = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MULT  = 4'd5,
    OP_DIV   = 4'd6,
    OP_MOD   = 4'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  read_index_q, read_index_d;
  logic [IW:0]    remaining_q, remaining_d;
  logic [63:0]    result_q, result_d;
  logic [IW-1:0]  result_index_q, result_index_d;
  logic           result_err_q, result_err_d;
  logic           result_valid_q, result_valid_d;

  logic signed [63:0] a64;
  logic signed [63:0] b64;
  logic signed [63:0] exec_res;
  logic               exec_err;

  // Operands are widened before the arithmetic so that MULT keeps the full
  // product and INT_MIN / -1 does not overflow.
  assign a64 = {{32{operand_a[31]}}, operand_a};
  assign b64 = {{32{operand_b[31]}}, operand_b};

  // Combinational ALU over the current readback; sampled only in FETCH.
  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (opcode)
      OP_ZERO:  exec_res = '0;
      OP_PASSA: exec_res = a64;
      OP_PASSB: exec_res = b64;
      OP_ADD:   exec_res = a64 + b64;
      OP_SUB:   exec_res = a64 - b64;
      OP_MULT:  exec_res = a64 * b64;
      OP_DIV: begin
        if (operand_b == 32'd0) begin
          exec_err = 1'b1;
        end else begin
          exec_res = a64 / b64;
        end
      end
      OP_MOD: begin
        if (operand_b == 32'd0) begin
          exec_err = 1'b1;
        end else begin
          exec_res = a64 % b64;
        end
      end
      default:  exec_err = 1'b1;
    endcase
  end

  // Next-state and datapath updates for the run sequencer.
  always_comb begin
    state_d        = state_q;
    read_index_d   = read_index_q;
    remaining_d    = remaining_q;
    result_d       = result_q;
    result_index_d = result_index_q;
    result_err_d   = result_err_q;
    result_valid_d = result_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          read_index_d = start_index;
          remaining_d  = count;
          state_d      = (count != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        // read_index was registered on the previous edge, so readback is settled.
        result_d       = exec_res;
        result_err_d   = exec_err;
        result_index_d = read_index_q;
        result_valid_d = 1'b1;
        state_d        = ST_OUT;
      end
      ST_OUT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          // Power-of-two depth: the natural IW-bit rollover is the slot wrap.
          read_index_d   = read_index_q + {{(IW-1){1'b0}}, 1'b1};
          remaining_d    = remaining_q - {{IW{1'b0}}, 1'b1};
          state_d        = (remaining_q == {{IW{1'b0}}, 1'b1}) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      state_q        <= ST_IDLE;
      read_index_q   <= '0;
      remaining_q    <= '0;
      result_q       <= '0;
      result_index_q <= '0;
      result_err_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_index_q   <= read_index_d;
      remaining_q    <= remaining_d;
      result_q       <= result_d;
      result_index_q <= result_index_d;
      result_err_q   <= result_err_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign read_index   = read_index_q;
  assign result       = result_q;
  assign result_index = result_index_q;
  assign result_err   = result_err_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_executor.sv
// tb/tb_instr_executor.sv - directed scoreboard bench for instr_executor
module tb_instr_executor;

  localparam int DEPTH = 32;
  localparam int IW    = 5;

  logic           clk = 1'b0;
  logic           reset_en;
  logic           start;
  logic [IW-1:0]  start_index;
  logic [IW:0]    count;
  logic [IW-1:0]  read_index;
  logic [3:0]     opcode;
  logic [31:0]    operand_a;
  logic [31:0]    operand_b;
  logic [63:0]    result;
  logic [IW-1:0]  result_index;
  logic           result_err;
  logic           result_valid;
  logic           result_ready;
  logic           busy;
  logic           done;

  logic [3:0]     slot_op [DEPTH];
  logic [31:0]    slot_a  [DEPTH];
  logic [31:0]    slot_b  [DEPTH];

  typedef struct packed {
    logic [63:0]   res;
    logic          err;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;
  int d0;

  always #5 clk = ~clk;

  assign opcode    = slot_op[read_index];
  assign operand_a = slot_a[read_index];
  assign operand_b = slot_b[read_index];

  always @(posedge clk) if (done === 1'b1) done_pulses <= done_pulses + 1;

  instr_executor #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_en     (reset_en),
    .start        (start),
    .start_index  (start_index),
    .count        (count),
    .read_index   (read_index),
    .opcode       (opcode),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result       (result),
    .result_index (result_index),
    .result_err   (result_err),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] r, input logic e, input logic [IW-1:0] i);
    sb.push_back('{res: r, err: e, idx: i});
  endtask

  task automatic set_slot(input int s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    slot_op[s] = op;
    slot_a[s]  = a;
    slot_b[s]  = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {63'd0, result_valid}, 64'd0);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_done"},  {63'd0, done}, 64'd0);
    check({tag, "_rdidx"}, {59'd0, read_index}, 64'd0);
    check({tag, "_res"},   result, 64'd0);
    check({tag, "_ridx"},  {59'd0, result_index}, 64'd0);
    check({tag, "_err"},   {63'd0, result_err}, 64'd0);
  endtask

  task automatic start_run(input logic [IW-1:0] idx, input logic [IW:0] cnt);
    start_index = idx;
    count       = cnt;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic collect(input int n, input int stall_beat, input int stall_cyc, input bit poke);
    exp_t          e;
    logic [63:0]   hold_r;
    logic [IW-1:0] hold_i;
    logic [IW-1:0] hold_ri;
    for (int k = 0; k < n; k++) begin
      int waits = 0;
      while (result_valid !== 1'b1 && waits < 20) begin
        tick();
        waits++;
      end
      check("beat_latency", 64'(waits), 64'd1);
      if (result_valid !== 1'b1) return;
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
        return;
      end
      e = sb.pop_front();
      check("result", result, e.res);
      check("result_err", {63'd0, result_err}, {63'd0, e.err});
      check("result_index", {59'd0, result_index}, {59'd0, e.idx});
      check("done_during_beat", {63'd0, done}, 64'd0);
      if (poke && k == 0) begin
        start = 1'b1;
        count = 6'd9;
      end
      if (k == stall_beat) begin
        result_ready = 1'b0;
        hold_r  = result;
        hold_i  = result_index;
        hold_ri = read_index;
        for (int s = 0; s < stall_cyc; s++) begin
          tick();
          check("stall_valid", {63'd0, result_valid}, 64'd1);
          check("stall_result", result, hold_r);
          check("stall_index", {59'd0, result_index}, {59'd0, hold_i});
          check("stall_read_index", {59'd0, read_index}, {59'd0, hold_ri});
        end
        result_ready = 1'b1;
      end
      tick();
      start = 1'b0;
    end
  endtask

  task automatic finish_run(input string tag);
    check({tag, "_done_hi"}, {63'd0, done}, 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    tick();
    check({tag, "_done_lo"}, {63'd0, done}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    check({tag, "_pulses"}, 64'(done_pulses - d0), 64'd1);
  endtask

  initial begin
    reset_en     = 1'b0;
    start        = 1'b0;
    start_index  = '0;
    count        = '0;
    result_ready = 1'b1;
    for (int s = 0; s < DEPTH; s++) set_slot(s, 4'd0, 32'd0, 32'd0);

    set_slot(0,  4'd3, 32'd5, -32'sd3);
    set_slot(1,  4'd4, 32'd5, -32'sd3);
    set_slot(2,  4'd5, 32'd65536, 32'd65536);
    set_slot(3,  4'd0, 32'd11, 32'd22);
    set_slot(4,  4'd6, -32'sd7, 32'd2);
    set_slot(5,  4'd7, -32'sd7, 32'd2);
    set_slot(6,  4'd1, -32'sd123, 32'd9);
    set_slot(7,  4'd2, 32'd4, -32'sd9);
    set_slot(8,  4'd6, 32'd5, 32'd0);
    set_slot(9,  4'd9, 32'd1, 32'd1);
    set_slot(10, 4'd4, 32'd1, 32'd2);
    set_slot(11, 4'd7, 32'd7, 32'd0);
    set_slot(12, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    set_slot(13, 4'd5, 32'h8000_0000, 32'h8000_0000);
    set_slot(14, 4'd7, 32'd7, -32'sd2);
    set_slot(15, 4'd6, 32'd7, -32'sd2);
    set_slot(30, 4'd1, -32'sd300, 32'd5);
    set_slot(31, 4'd2, 32'd1, 32'd31);

    tick();
    tick();
    check_reset_outputs("reset");
    reset_en = 1'b1;
    tick();

    d0 = done_pulses;
    push(64'd2, 1'b0, 5'd0);
    push(64'd8, 1'b0, 5'd1);
    push(64'd4294967296, 1'b0, 5'd2);
    push(64'd0, 1'b0, 5'd3);
    push(-64'sd3, 1'b0, 5'd4);
    push(-64'sd1, 1'b0, 5'd5);
    push(-64'sd123, 1'b0, 5'd6);
    push(-64'sd9, 1'b0, 5'd7);
    start_run(5'd0, 6'd8);
    collect(8, -1, 0, 1'b0);
    finish_run("basic");

    d0 = done_pulses;
    push(64'd2, 1'b0, 5'd0);
    push(64'd8, 1'b0, 5'd1);
    push(64'd4294967296, 1'b0, 5'd2);
    push(64'd0, 1'b0, 5'd3);
    start_run(5'd0, 6'd4);
    collect(4, 1, 5, 1'b0);
    finish_run("stall");

    d0 = done_pulses;
    push(-64'sd300, 1'b0, 5'd30);
    push(64'd31, 1'b0, 5'd31);
    push(64'd2, 1'b0, 5'd0);
    push(64'd8, 1'b0, 5'd1);
    start_run(5'd30, 6'd4);
    collect(4, -1, 0, 1'b0);
    finish_run("wrap");

    d0 = done_pulses;
    push(64'd0, 1'b1, 5'd8);
    push(64'd0, 1'b1, 5'd9);
    push(-64'sd1, 1'b0, 5'd10);
    push(64'd0, 1'b1, 5'd11);
    push(64'h0000_0000_8000_0000, 1'b0, 5'd12);
    push(64'h4000_0000_0000_0000, 1'b0, 5'd13);
    push(64'd1, 1'b0, 5'd14);
    push(-64'sd3, 1'b0, 5'd15);
    start_run(5'd8, 6'd8);
    collect(8, -1, 0, 1'b0);
    finish_run("errors");

    d0 = done_pulses;
    start_run(5'd5, 6'd0);
    check("cnt0_done_hi", {63'd0, done}, 64'd1);
    check("cnt0_no_valid", {63'd0, result_valid}, 64'd0);
    tick();
    check("cnt0_done_lo", {63'd0, done}, 64'd0);
    check("cnt0_idle", {63'd0, busy}, 64'd0);
    tick();
    check("cnt0_still_no_valid", {63'd0, result_valid}, 64'd0);
    check("cnt0_pulses", 64'(done_pulses - d0), 64'd1);

    d0 = done_pulses;
    push(64'd2, 1'b0, 5'd0);
    push(64'd8, 1'b0, 5'd1);
    push(64'd4294967296, 1'b0, 5'd2);
    start_run(5'd0, 6'd3);
    collect(3, -1, 0, 1'b1);
    finish_run("poke");
    tick();
    tick();
    check("poke_no_extra_valid", {63'd0, result_valid}, 64'd0);
    check("poke_no_extra_busy", {63'd0, busy}, 64'd0);

    d0 = done_pulses;
    start_run(5'd0, 6'd2);
    result_ready = 1'b0;
    tick();
    check("abort_valid_before", {63'd0, result_valid}, 64'd1);
    #2;
    reset_en = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    check("abort_no_done", 64'(done_pulses - d0), 64'd0);
    reset_en = 1'b1;
    result_ready = 1'b1;
    tick();
    check("abort_idle_after", {63'd0, busy}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
